mem_access_sequencer: RTL and testbench

// - MEM-stage consumer of the decoded control word: takes mem_read/mem_write/indirect_enable/mem_byte_enable

---
 rtl/mem_access_sequencer_pkg.sv | 40 ++++
 rtl/mem_access_sequencer.sv | 145 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer_pkg
// Brief   : Shared types for the MEM-stage data-cache access sequencer:
//           sequencer state, decoded memory operation, and the op decoder.
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_sequencer_pkg;

   // Byte enable used for full-word pointer reads and indirect stores
   localparam logic [1:0] c_BE_WORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2,
      DONE = 2'd3
   } mem_seq_state_t;

   typedef enum logic [1:0] {
      READ  = 2'd0,
      WRITE = 2'd1,
      LDI   = 2'd2,
      STI   = 2'd3
   } mem_op_t;

   // Indirect flag dominates; otherwise a set write flag wins over read
   function automatic mem_op_t decode_op(input logic i_rd, input logic i_wr, input logic i_ind);
      mem_op_t v_op;
      if (i_ind)
         v_op = i_rd ? LDI : STI;
      else if (i_wr)
         v_op = WRITE;
      else
         v_op = READ;
      return v_op;
   endfunction

endpackage : mem_access_sequencer_pkg
`default_nettype wire

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer
// Brief   : Turns the MEM-stage control word into one (READ/WRITE) or two
//           (LDI/STI) data-cache transactions, stalls the pipeline until the
//           access finishes and returns the loaded word.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stage_valid,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             indirect_enable,
   input  logic [1:0]       byte_enable,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] store_data,
   input  logic             dcache_resp,
   input  logic [WIDTH-1:0] dcache_rdata,
   output logic             dcache_read,
   output logic             dcache_write,
   output logic [WIDTH-1:0] dcache_address,
   output logic [1:0]       dcache_byte_en,
   output logic [WIDTH-1:0] dcache_wdata,
   output logic [WIDTH-1:0] load_data,
   output logic             access_done,
   output logic             stall
);

   mem_seq_state_t   r_state;
   mem_seq_state_t   w_state_nxt;
   mem_op_t          r_op;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [1:0]       r_be;
   logic [WIDTH-1:0] r_ptr;
   logic [WIDTH-1:0] r_load_data;
   logic             w_start;

   assign w_start   = stage_valid & (mem_read | mem_write | indirect_enable);
   assign load_data = r_load_data;

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Request latches at accept, pointer capture after the first indirect read, load data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op        <= READ;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_ptr       <= '0;
         r_load_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_op    <= decode_op(mem_read, mem_write, indirect_enable);
                  r_addr  <= addr;
                  r_wdata <= store_data;
                  r_be    <= byte_enable;
               end
            end
            ACC1: begin
               if (dcache_resp) begin
                  if (r_op == READ)
                     r_load_data <= dcache_rdata;
                  if (r_op == LDI || r_op == STI)
                     r_ptr <= {dcache_rdata[WIDTH-1:1], 1'b0};
               end
            end
            ACC2: begin
               if (dcache_resp && r_op == LDI)
                  r_load_data <= dcache_rdata;
            end
            default: ;
         endcase
      end
   end

   // Next-state decode and Moore cache request outputs
   always_comb begin
      w_state_nxt    = r_state;
      dcache_read    = 1'b0;
      dcache_write   = 1'b0;
      dcache_address = '0;
      dcache_byte_en = '0;
      dcache_wdata   = '0;
      access_done    = 1'b0;
      stall          = 1'b0;
      case (r_state)
         IDLE: begin
            stall = w_start;
            if (w_start)
               w_state_nxt = ACC1;
         end
         ACC1: begin
            stall          = 1'b1;
            dcache_address = r_addr;
            if (r_op == WRITE) begin
               dcache_write   = 1'b1;
               dcache_wdata   = r_wdata;
               dcache_byte_en = r_be;
            end else begin
               dcache_read    = 1'b1;
               // Indirect ops fetch a full-word pointer first
               dcache_byte_en = (r_op == READ) ? r_be : c_BE_WORD;
            end
            if (dcache_resp)
               w_state_nxt = (r_op == LDI || r_op == STI) ? ACC2 : DONE;
         end
         ACC2: begin
            stall          = 1'b1;
            dcache_address = r_ptr;
            dcache_byte_en = c_BE_WORD;
            if (r_op == STI) begin
               dcache_write = 1'b1;
               dcache_wdata = r_wdata;
            end else begin
               dcache_read  = 1'b1;
            end
            if (dcache_resp)
               w_state_nxt = DONE;
         end
         DONE: begin
            access_done = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule : mem_access_sequencer
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_sequencer
// Brief   : Self-checking bench: directed LC-3b memory scenarios followed by
//           randomized transactions against a word-memory reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stage_valid, mem_read, mem_write, indirect_enable;
   logic [1:0]  byte_enable;
   logic [15:0] addr, store_data;
   logic        dcache_resp;
   logic [15:0] dcache_rdata;
   logic        dcache_read, dcache_write;
   logic [15:0] dcache_address;
   logic [1:0]  dcache_byte_en;
   logic [15:0] dcache_wdata, load_data;
   logic        access_done, stall;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [logic [15:0]];
   logic [15:0] model_load;

   always #5 clk = ~clk;

   mem_access_sequencer #(.WIDTH(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .stage_valid     (stage_valid),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .indirect_enable (indirect_enable),
      .byte_enable     (byte_enable),
      .addr            (addr),
      .store_data      (store_data),
      .dcache_resp     (dcache_resp),
      .dcache_rdata    (dcache_rdata),
      .dcache_read     (dcache_read),
      .dcache_write    (dcache_write),
      .dcache_address  (dcache_address),
      .dcache_byte_en  (dcache_byte_en),
      .dcache_wdata    (dcache_wdata),
      .load_data       (load_data),
      .access_done     (access_done),
      .stall           (stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Unwritten locations return a deterministic address-derived word
   function automatic logic [15:0] mrd(input logic [15:0] a);
      if (mem.exists(a))
         return mem[a];
      return a ^ 16'hA5C3;
   endfunction

   task automatic idle_inputs();
      stage_valid     = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      indirect_enable = 1'b0;
      byte_enable     = 2'b00;
      addr            = 16'h0;
      store_data      = 16'h0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_req"},  {dcache_read, dcache_write}, 2'b00);
      check({tag, "_done"}, access_done, 1'b0);
      check({tag, "_stall"}, stall, 1'b0);
      check({tag, "_load"}, load_data, model_load);
   endtask

   // One complete access; wfix >= 0 forces the response wait for every access
   task automatic run_txn(input logic rd, input logic wr, input logic ind,
                          input logic [1:0] be, input logic [15:0] a,
                          input logic [15:0] d, input int wfix);
      int          n;
      logic        kind [2];
      logic [15:0] ea   [2];
      logic [1:0]  eb   [2];
      logic [15:0] last_rd;
      int          w;
      // Expected transaction list from the op rules
      if (ind) begin
         n = 2;
         kind[0] = 1'b0; ea[0] = a; eb[0] = 2'b11;
         kind[1] = !rd;  ea[1] = mrd(a) & 16'hFFFE; eb[1] = 2'b11;
      end else begin
         n = 1;
         kind[0] = wr; ea[0] = a; eb[0] = be;
         kind[1] = 1'b0; ea[1] = 16'h0; eb[1] = 2'b00;
      end
      last_rd = model_load;

      @(negedge clk);
      stage_valid = 1'b1; mem_read = rd; mem_write = wr; indirect_enable = ind;
      byte_enable = be; addr = a; store_data = d;
      #1;
      check("accept_stall", stall, 1'b1);
      check("accept_req", {dcache_read, dcache_write}, 2'b00);
      @(posedge clk);
      #1;
      // Post-accept input changes must not matter
      stage_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      indirect_enable = 1'($urandom); byte_enable = 2'($urandom);
      addr = 16'($urandom); store_data = 16'($urandom);

      for (int k = 0; k < n; k++) begin
         w = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
         for (int c = 0; c <= w; c++) begin
            @(negedge clk);
            dcache_resp = 1'b0;
            check("req_kind", {dcache_read, dcache_write}, kind[k] ? 2'b01 : 2'b10);
            check("req_addr", dcache_address, ea[k]);
            check("req_be", dcache_byte_en, eb[k]);
            if (kind[k])
               check("req_wdata", dcache_wdata, d);
            check("busy_stall", stall, 1'b1);
            check("busy_done", access_done, 1'b0);
            if (c == w) begin
               dcache_resp = 1'b1;
               if (kind[k]) begin
                  dcache_rdata = 16'($urandom);
                  mem[ea[k]] = {eb[k][1] ? d[15:8] : mrd(ea[k])[15:8],
                                eb[k][0] ? d[7:0]  : mrd(ea[k])[7:0]};
               end else begin
                  dcache_rdata = mrd(ea[k]);
                  last_rd = dcache_rdata;
               end
            end
         end
      end
      if (!kind[n-1])
         model_load = last_rd;

      @(negedge clk);
      dcache_resp = 1'b0;
      dcache_rdata = 16'($urandom);
      check("done_pulse", access_done, 1'b1);
      check("done_stall", stall, 1'b0);
      check("done_req", {dcache_read, dcache_write}, 2'b00);
      check("done_load", load_data, model_load);
      idle_inputs();
      @(negedge clk);
      check_quiet("post");
   endtask

   task automatic no_access(input logic sv, input logic rd);
      @(negedge clk);
      idle_inputs();
      stage_valid = sv; mem_read = rd;
      // A stray response while idle must be ignored
      dcache_resp = 1'b1; dcache_rdata = 16'hDEAD;
      #1;
      check("noop_stall", stall, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dcache_resp = 1'b0;
         check_quiet("noop");
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      dcache_resp  = 1'b0;
      dcache_rdata = 16'h0;
      model_load   = 16'h0;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_addr", dcache_address, 16'h0);
      check("rst_wdata", dcache_wdata, 16'h0);
      check("rst_be", dcache_byte_en, 2'b00);
      check_quiet("rst");
      reset = 1'b0;

      mem[16'h1000] = 16'hBEEF;
      mem[16'h3000] = 16'h4001;
      mem[16'h4000] = 16'h1234;
      mem[16'h3002] = 16'h5000;

      // Directed scenarios
      run_txn(1'b1, 1'b0, 1'b0, 2'b11, 16'h1000, 16'h0000, 2);
      check("read_beef", load_data, 16'hBEEF);
      run_txn(1'b0, 1'b1, 1'b0, 2'b10, 16'h2001, 16'h4200, 1);
      check("stb_keep", load_data, 16'hBEEF);
      run_txn(1'b1, 1'b0, 1'b1, 2'b01, 16'h3000, 16'h0000, 0);
      check("ldi_val", load_data, 16'h1234);
      run_txn(1'b0, 1'b0, 1'b1, 2'b00, 16'h3002, 16'h00AA, 1);
      check("sti_mem", mrd(16'h5000), 16'h00AA);
      run_txn(1'b1, 1'b1, 1'b0, 2'b11, 16'h2222, 16'h7777, 0);
      check("rw_is_write", mrd(16'h2222), 16'h7777);

      no_access(1'b1, 1'b0);
      no_access(1'b0, 1'b1);

      // Reset during the pointer-target read of an LDI, late response afterwards
      @(negedge clk);
      stage_valid = 1'b1; mem_read = 1'b1; indirect_enable = 1'b1;
      byte_enable = 2'b11; addr = 16'h3000;
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      dcache_resp = 1'b1; dcache_rdata = 16'h4001;
      @(negedge clk);
      dcache_resp = 1'b0;
      check("mid_acc2_addr", dcache_address, 16'h4000);
      check("mid_acc2_req", {dcache_read, dcache_write}, 2'b10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_load = 16'h0;
      dcache_resp = 1'b1; dcache_rdata = 16'h1234;
      check_quiet("rst_mid");
      check("rst_mid_addr", dcache_address, 16'h0);
      @(negedge clk);
      dcache_resp = 1'b0;
      check_quiet("rst_late");

      // Randomized transactions
      for (int t = 0; t < 200; t++) begin
         logic        rd, wr, ind;
         logic [15:0] a;
         rd  = 1'($urandom);
         wr  = 1'($urandom);
         ind = ($urandom_range(0, 3) == 0);
         if (!rd && !wr && !ind)
            rd = 1'b1;
         a = ($urandom_range(0, 1) == 0) ? {12'h000, 4'($urandom)} : 16'($urandom);
         run_txn(rd, wr, ind, 2'($urandom), a, 16'($urandom), -1);
         if ($urandom_range(0, 19) == 0)
            no_access(1'b1, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_access_sequencer
`default_nettype wire
